// File: rtl/axi_ddr_rd_frame_sched_pkg.sv
// Shared constants and state encoding for the frame-level DDR read scheduler.
package axi_ddr_rd_frame_sched_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int BEAT_BYTES     = 8;
    localparam int BURST_LEN      = 64;
    localparam int FIFO_DEPTH     = 1024;
    localparam int FIFO_CNT_W     = 11;
    localparam int BEATS_W        = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

endpackage

// File: rtl/axi_ddr_rd_frame_sched.sv
// Walks one video frame in DDR per frame_start, issuing FIFO-space-gated bursts to the
// single-burst read engine and reporting frame completion, overrun and short bursts.
module axi_ddr_rd_frame_sched
    import axi_ddr_rd_frame_sched_pkg::*;
(
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESETN,
    input  logic                      enable,
    input  logic                      frame_start,
    input  logic [AXI_ADDR_WIDTH-1:0] frame_base,
    input  logic [BEATS_W-1:0]        frame_beats,
    input  logic [FIFO_CNT_W-1:0]     fifo_wr_cnt,
    output logic                      Recv_START,
    output logic [7:0]                Recv_BurstLen,
    output logic [AXI_ADDR_WIDTH-1:0] Recv_Addr,
    input  logic                      Recv_fifo_W_en,
    input  logic                      Recv_DONE,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      frame_overrun,
    output logic                      burst_err
);

    localparam int NW = FIFO_CNT_W + 2;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [BEATS_W-1:0]        rem_q, rem_d;
    logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]                rlen_q, rlen_d;
    logic [8:0]                beat_cnt_q, beat_cnt_d;
    logic                      gap_q, gap_d;
    logic                      err_q, err_d;
    logic                      ovr_q, ovr_d;
    logic                      restart_q, restart_d;
    logic [AXI_ADDR_WIDTH-1:0] pbase_q, pbase_d;
    logic [BEATS_W-1:0]        pbeats_q, pbeats_d;

    logic [BEATS_W-1:0] len_w;
    logic [NW-1:0]      need_w;
    logic               fits_w;
    logic [8:0]         beats_got_w;

    assign len_w       = (rem_q > BEATS_W'(BURST_LEN)) ? BEATS_W'(BURST_LEN) : rem_q;
    // Nothing is in flight while in CHECK, so only the new burst must fit.
    assign need_w      = NW'(fifo_wr_cnt) + NW'(len_w);
    assign fits_w      = need_w <= NW'(FIFO_DEPTH);
    assign beats_got_w = beat_cnt_q + {8'd0, Recv_fifo_W_en};

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        rem_d       = rem_q;
        raddr_d     = raddr_q;
        rlen_d      = rlen_q;
        beat_cnt_d  = beat_cnt_q;
        gap_d       = gap_q;
        err_d       = err_q;
        ovr_d       = 1'b0;
        restart_d   = restart_q;
        pbase_d     = pbase_q;
        pbeats_d    = pbeats_q;

        unique case (state_q)
            ST_IDLE: begin
                restart_d = 1'b0;
                if (frame_start && enable) begin
                    next_addr_d = frame_base;
                    rem_d       = frame_beats;
                    err_d       = 1'b0;
                    state_d     = (frame_beats == '0) ? ST_FIN : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!enable) begin
                    restart_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (restart_q) begin
                    next_addr_d = pbase_q;
                    rem_d       = pbeats_q;
                    restart_d   = 1'b0;
                    state_d     = (pbeats_q == '0) ? ST_FIN : ST_CHECK;
                end else if (fits_w) begin
                    raddr_d    = next_addr_q;
                    rlen_d     = 8'(len_w);
                    beat_cnt_d = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (Recv_fifo_W_en)
                    beat_cnt_d = beat_cnt_q + 9'd1;
                if (Recv_DONE) begin
                    if (beats_got_w != {1'b0, rlen_q})
                        err_d = 1'b1;
                    next_addr_d = next_addr_q + AXI_ADDR_WIDTH'(rlen_q) * AXI_ADDR_WIDTH'(BEAT_BYTES);
                    rem_d       = rem_q - BEATS_W'(rlen_q);
                    gap_d       = 1'b0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                // Two low cycles let the engine's edge detector re-arm.
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (restart_q) begin
                    next_addr_d = pbase_q;
                    rem_d       = pbeats_q;
                    restart_d   = 1'b0;
                    state_d     = (pbeats_q == '0) ? ST_FIN : ST_CHECK;
                end else begin
                    state_d = (rem_q == '0) ? ST_FIN : ST_CHECK;
                end
            end
            ST_FIN: begin
                if (frame_start && enable) begin
                    next_addr_d = frame_base;
                    rem_d       = frame_beats;
                    err_d       = 1'b0;
                    restart_d   = 1'b0;
                    state_d     = (frame_beats == '0) ? ST_FIN : ST_CHECK;
                end else if (restart_q) begin
                    // Restart requested during the final gap of the previous frame.
                    next_addr_d = pbase_q;
                    rem_d       = pbeats_q;
                    restart_d   = 1'b0;
                    state_d     = (pbeats_q == '0) ? ST_FIN : ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Placed last so a new request in the same cycle as a restart load wins.
        if (frame_start && (state_q != ST_IDLE) && (state_q != ST_FIN)) begin
            ovr_d     = 1'b1;
            restart_d = 1'b1;
            pbase_d   = frame_base;
            pbeats_d  = frame_beats;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            next_addr_q <= '0;
            rem_q       <= '0;
            raddr_q     <= '0;
            rlen_q      <= '0;
            beat_cnt_q  <= '0;
            gap_q       <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            restart_q   <= 1'b0;
            pbase_q     <= '0;
            pbeats_q    <= '0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            rem_q       <= rem_d;
            raddr_q     <= raddr_d;
            rlen_q      <= rlen_d;
            beat_cnt_q  <= beat_cnt_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            restart_q   <= restart_d;
            pbase_q     <= pbase_d;
            pbeats_q    <= pbeats_d;
        end
    end

    assign Recv_START    = (state_q == ST_ISSUE);
    assign Recv_Addr     = raddr_q;
    assign Recv_BurstLen = rlen_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = (state_q == ST_FIN);
    assign frame_overrun = ovr_q;
    assign burst_err     = err_q;

endmodule
